// File: rtl/uart_tx_source.sv
// uart_tx_source: valid/ready byte FIFO feeding an LSB-first 8N1/8N2 UART serializer.
// Define UART_TX_PARITY_EN to add a parity bit (even; odd when parity_odd is set).
module uart_tx_source #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_odd,
`endif
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_done
);

    localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BaudReload = 16'(CLK_DIV - 1);
    localparam logic        LastStop   = (STOP_BITS == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    logic [7:0]       head;

    state_e           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       shreg_q, shreg_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Full/empty come from registered pointers only, so a pop never frees a slot same-cycle.
    assign full       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrW{1'b0}}};
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q[AddrW-1:0]];
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != StIdle) || (fifo_level != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= in_data;
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pop        = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    baud_d  = BaudReload;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            StStart: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d    = BaudReload;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                tx = shreg_q[0];
                if (baud_q == '0) begin
                    baud_d  = BaudReload;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        stop_idx_d = 1'b0;
                        state_d    = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                tx = parity_q ^ parity_odd;
                if (baud_q == '0) begin
                    baud_d     = BaudReload;
                    stop_idx_d = 1'b0;
                    state_d    = StStop;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            StStop: begin
                tx = 1'b1;
                if (baud_q == '0) begin
                    if (stop_idx_q == LastStop) begin
                        frame_done = 1'b1;
                        // Back-to-back frames: reload straight into START without an idle cycle.
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_d = head;
                            baud_d  = BaudReload;
                            state_d = StStart;
`ifdef UART_TX_PARITY_EN
                            parity_d = ^head;
`endif
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        baud_d     = BaudReload;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= BaudReload;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shreg_q    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_source.sv
// Bench for uart_tx_source: a line-level UART receiver model pops expected bytes from a queue.
module tb_uart_tx_source;

    localparam int D  = 4;
    localparam int D2 = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB  = 10 + PB;
    localparam int FL  = NB * D;
    localparam int FL2 = (11 + PB) * D2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, tx, busy, frame_done;
    logic [2:0] fifo_level;

    logic       in_valid2 = 1'b0;
    logic [7:0] in_data2  = 8'h00;
    logic       in_ready2, tx2, busy2, frame_done2;
    logic [2:0] fifo_level2;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int contig = 0;
    int last_end = -10;
    logic [7:0] exp_q[$];

    uart_tx_source #(.CLK_DIV(D), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frame_done (frame_done)
    );

    uart_tx_source #(.CLK_DIV(D2), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_data    (in_data2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx2),
        .busy       (busy2),
        .fifo_level (fifo_level2),
        .frame_done (frame_done2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    // Receiver model: captures whole frames from tx, checks shape and data against exp_q.
    initial begin : monitor
        logic [FL-1:0] line;
        logic [7:0]    got;
        logic [7:0]    exp;
        logic          aborted, fd_bad, shape_bad;
        int            start;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                start   = cyc;
                line    = '0;
                aborted = 1'b0;
                fd_bad  = (frame_done !== 1'b0);
                for (int i = 1; i < FL; i++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    line[i] = tx;
                    if (frame_done !== (i == FL - 1)) fd_bad = 1'b1;
                end
                if (!aborted) begin
                    shape_bad = 1'b0;
                    for (int b = 0; b < NB; b++)
                        for (int k = 1; k < D; k++)
                            if (line[b*D+k] !== line[b*D]) shape_bad = 1'b1;
                    for (int b = 0; b < 8; b++) got[b] = line[(b+1)*D];
                    check("frame_bit_hold", int'(shape_bad), 0);
                    check("frame_stop_bit", int'(line[(NB-1)*D]), 1);
                    check("frame_done_position", int'(fd_bad), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %02h, required no frame", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("frame_data", int'(got), int'(exp));
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", int'(line[9*D]), int'(^exp ^ parity_odd));
`endif
                    end
                    if (start == last_end + 1) contig++;
                    last_end = cyc;
                    frames++;
                end
            end
        end
    end

    initial begin : stim
        int n, f0, c0, accepted, fd_at, stop_len;
        logic rdy, ready_bad;
        logic [7:0] got2;
        logic [FL2-1:0] line2;
        int exp_lvl[12] = '{0, 1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4};

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        check("reset_tx", int'(tx), 1);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_fifo_level", int'(fifo_level), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_tx2", int'(tx2), 1);

        // Single byte 0x55: latency, frame_done timing, busy release
        step();
        in_valid = 1'b1;
        in_data  = 8'h55;
        exp_q.push_back(8'h55);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("t1_tx_high_after_push_edge", int'(tx), 1);
        check("t1_level_after_push", int'(fifo_level), 1);
        check("t1_busy_after_push", int'(busy), 1);
        @(negedge clock);
        check("t1_start_bit", int'(tx), 0);
        check("t1_level_after_pop", int'(fifo_level), 0);
        n = 0;
        while (frame_done !== 1'b1 && n < FL + 10) begin
            @(negedge clock);
            n++;
        end
        check("t1_frame_done_cycle", n, FL - 1);
        @(negedge clock);
        check("t1_busy_dropped", int'(busy), 0);
        check("t1_tx_idle", int'(tx), 1);

        // Back-to-back A3, 00, FF: contiguous frames
        step();
        c0 = contig;
        f0 = frames;
        in_valid = 1'b1;
        in_data = 8'hA3; exp_q.push_back(8'hA3); step();
        in_data = 8'h00; exp_q.push_back(8'h00); step();
        in_data = 8'hFF; exp_q.push_back(8'hFF); step();
        in_valid = 1'b0;
        wait_idle(3 * FL + 20, "t2_idle");
        check("t2_frames", frames - f0, 3);
        check("t2_contiguous", contig - c0, 2);
        check("t2_queue_drained", exp_q.size(), 0);

        // Overflow: 6 bytes offered, 5 accepted, in_ready tracks full
        step();
        f0 = frames;
        accepted = 0;
        in_valid = 1'b1;
        in_data  = 8'h10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            rdy = in_ready;
            check("t3_level", int'(fifo_level), exp_lvl[c]);
            check("t3_in_ready", int'(rdy), int'(exp_lvl[c] != 4));
            @(posedge clock);
            if (rdy) begin
                exp_q.push_back(in_data);
                accepted++;
            end
            #1;
            if (rdy && accepted < 6) in_data = in_data + 8'd1;
        end
        in_valid = 1'b0;
        check("t3_accepted", accepted, 5);
        n = 0;
        ready_bad = 1'b0;
        @(negedge clock);
        while (fifo_level == 3'd4 && n < FL + 10) begin
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clock);
            n++;
        end
        check("t3_ready_low_while_full", int'(ready_bad), 0);
        check("t3_level_after_pop", int'(fifo_level), 3);
        check("t3_ready_after_pop", int'(in_ready), 1);
        wait_idle(5 * FL + 50, "t3_idle");
        check("t3_frames", frames - f0, 5);
        check("t3_queue_drained", exp_q.size(), 0);

        // Reset during data bit 3 with two bytes queued
        step();
        f0 = frames;
        in_valid = 1'b1;
        in_data = 8'h31; exp_q.push_back(8'h31); step();
        in_data = 8'h32; exp_q.push_back(8'h32); step();
        in_data = 8'h33; exp_q.push_back(8'h33); step();
        in_valid = 1'b0;
        repeat (15) step();
        @(negedge clock);
        check("t4_level_before_reset", int'(fifo_level), 2);
        check("t4_busy_before_reset", int'(busy), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clock);
        check("t4_tx_after_reset", int'(tx), 1);
        check("t4_busy_after_reset", int'(busy), 0);
        check("t4_level_after_reset", int'(fifo_level), 0);
        check("t4_ready_after_reset", int'(in_ready), 1);
        step();
        in_valid = 1'b1;
        in_data  = 8'h41;
        exp_q.push_back(8'h41);
        step();
        in_valid = 1'b0;
        wait_idle(FL + 20, "t4_idle");
        check("t4_frames", frames - f0, 1);
        check("t4_queue_drained", exp_q.size(), 0);

        // Two stop bits, CLK_DIV=8: 0x0F
        step();
        in_valid2 = 1'b1;
        in_data2  = 8'h0F;
        step();
        in_valid2 = 1'b0;
        @(negedge clock);
        check("t5_tx_high_after_push_edge", int'(tx2), 1);
        fd_at = -1;
        line2 = '0;
        for (int i = 0; i < FL2 + 8; i++) begin
            @(negedge clock);
            if (i < FL2) line2[i] = tx2;
            if (frame_done2 === 1'b1 && fd_at < 0) fd_at = i;
        end
        for (int b = 0; b < 8; b++) got2[b] = line2[(b+1)*D2];
        check("t5_start_bit", int'(line2[0]), 0);
        check("t5_data", int'(got2), 8'h0F);
        check("t5_last_bit_before_stop", int'(line2[(9+PB)*D2-1]), 0);
        stop_len = 0;
        for (int j = (9 + PB) * D2; j < FL2; j++) if (line2[j]) stop_len++;
        check("t5_stop_len", stop_len, 2 * D2);
        check("t5_frame_done_cycle", fd_at, FL2 - 1);
        check("t5_busy_after", int'(busy2), 0);
        check("t5_tx_idle", int'(tx2), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
